ifu_fill_arbiter: RTL

Single-outstanding fill controller between the IFU instruction cache, the IFU prefetcher and the shared instruction-memory port. It accepts line-fill requests from the cache (miss path) and the prefetcher, and arbitrates with fixed cache priority. It issues one memory request at a time, matches the returning line by tag, and delivers it to the cache insertion path as a one-cycle fill pulse.

---
 rtl/ifu_fill_arbiter_if.sv | 40 ++++
 rtl/ifu_fill_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fill_arbiter_if.sv
// Bundle of request, memory and fill signals around the IFU fill arbiter.
// The slave modport is the arbiter's view; master is the surrounding cache/prefetcher/memory side.

interface ifu_fill_arbiter_if #(
  parameter int unsigned TAG_WIDTH  = 28,
  parameter int unsigned LINE_WIDTH = 128
);
  logic [TAG_WIDTH-1:0]  cache_reqTagIn;
  logic                  cache_reqValidIn;
  logic                  cache_reqReadyOut;
  logic [TAG_WIDTH-1:0]  pf_reqTagIn;
  logic                  pf_reqValidIn;
  logic                  pf_reqReadyOut;
  logic [TAG_WIDTH-1:0]  mem_reqTagOut;
  logic                  mem_reqValidOut;
  logic                  mem_reqReadyIn;
  logic [TAG_WIDTH-1:0]  mem_rspTagIn;
  logic [LINE_WIDTH-1:0] mem_rspInsLineIn;
  logic                  mem_rspValidIn;
  logic [TAG_WIDTH-1:0]  fill_tagOut;
  logic [LINE_WIDTH-1:0] fill_lineOut;
  logic                  fill_validOut;
  logic                  fill_srcOut;
  logic                  busyOut;
  logic                  timeoutOut;

  modport slave (
    input  cache_reqTagIn, cache_reqValidIn, pf_reqTagIn, pf_reqValidIn,
    input  mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineIn, mem_rspValidIn,
    output cache_reqReadyOut, pf_reqReadyOut, mem_reqTagOut, mem_reqValidOut,
    output fill_tagOut, fill_lineOut, fill_validOut, fill_srcOut, busyOut, timeoutOut
  );

  modport master (
    output cache_reqTagIn, cache_reqValidIn, pf_reqTagIn, pf_reqValidIn,
    output mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineIn, mem_rspValidIn,
    input  cache_reqReadyOut, pf_reqReadyOut, mem_reqTagOut, mem_reqValidOut,
    input  fill_tagOut, fill_lineOut, fill_validOut, fill_srcOut, busyOut, timeoutOut
  );
endinterface

// File: rtl/ifu_fill_arbiter.sv
// Single-outstanding line-fill controller: cache misses beat prefetches, one memory request in
// flight, tag-matched response delivered as a one-cycle fill. IFU_FILL_TIMEOUT_EN adds reissue.

module ifu_fill_arbiter #(
  parameter int unsigned TAG_WIDTH      = 28,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              Clock,
  input logic              Rst,
  ifu_fill_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFill} state_e;

  state_e                state_q, state_d;
  logic [TAG_WIDTH-1:0]  req_tag_q, req_tag_d;
  logic                  req_src_q, req_src_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;

  logic                  cache_ready;
  logic                  pf_ready;
  logic                  mem_valid;
  logic [TAG_WIDTH-1:0]  mem_tag;
  logic                  fill_valid;
  logic [TAG_WIDTH-1:0]  fill_tag;
  logic [LINE_WIDTH-1:0] fill_line;
  logic                  fill_src;
  logic                  rsp_match;
  logic                  promote_ok;

  assign rsp_match  = bus.mem_rspValidIn && (bus.mem_rspTagIn == req_tag_q);
  // A cache miss for the line already being prefetched rides on the outstanding request.
  assign promote_ok = ((state_q == StIssue) || (state_q == StWait)) && req_src_q &&
                      (bus.cache_reqTagIn == req_tag_q);

`ifdef IFU_FILL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            cnt_expired;

  assign cnt_expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_src_d   = req_src_q;
    line_d      = line_q;
    cache_ready = 1'b0;
    pf_ready    = 1'b0;
    mem_valid   = 1'b0;
    mem_tag     = '0;
    fill_valid  = 1'b0;
    fill_tag    = '0;
    fill_line   = '0;
    fill_src    = 1'b0;
`ifdef IFU_FILL_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        cache_ready = 1'b1;
        pf_ready    = !bus.cache_reqValidIn;
        if (bus.cache_reqValidIn) begin
          req_tag_d = bus.cache_reqTagIn;
          req_src_d = 1'b0;
          state_d   = StIssue;
        end else if (bus.pf_reqValidIn) begin
          req_tag_d = bus.pf_reqTagIn;
          req_src_d = 1'b1;
          state_d   = StIssue;
        end
      end

      StIssue: begin
        mem_valid = 1'b1;
        mem_tag   = req_tag_q;
        if (bus.mem_reqReadyIn) begin
          state_d = StWait;
`ifdef IFU_FILL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      StWait: begin
        if (rsp_match) begin
          line_d  = bus.mem_rspInsLineIn;
          state_d = StFill;
`ifdef IFU_FILL_TIMEOUT_EN
        end else if (cnt_expired) begin
          state_d   = StIssue;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      StFill: begin
        fill_valid = 1'b1;
        fill_tag   = req_tag_q;
        fill_line  = line_q;
        fill_src   = req_src_q;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (promote_ok) begin
      cache_ready = 1'b1;
      if (bus.cache_reqValidIn) begin
        req_src_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q   <= StIdle;
      req_tag_q <= '0;
      req_src_q <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      req_src_q <= req_src_d;
      line_q    <= line_d;
    end
  end

`ifdef IFU_FILL_TIMEOUT_EN
  always_ff @(posedge Clock) begin
    if (Rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeoutOut = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus.timeoutOut     = 1'b0;
`endif

  assign bus.cache_reqReadyOut = cache_ready;
  assign bus.pf_reqReadyOut    = pf_ready;
  assign bus.mem_reqValidOut   = mem_valid;
  assign bus.mem_reqTagOut     = mem_tag;
  assign bus.fill_validOut     = fill_valid;
  assign bus.fill_tagOut       = fill_tag;
  assign bus.fill_lineOut      = fill_line;
  assign bus.fill_srcOut       = fill_src;
  assign bus.busyOut           = (state_q != StIdle);

endmodule
